led_driver: RTL and testbench

//  Presentation and edit engine of the digital clock. Turns the wall-clock counter (Unix seconds) into eight
//  BCD digits for the time, date, alarm or timer page selected by the mode FSM's state, and edits the

---
 rtl/led_driver_pkg.sv | 110 +++++++++++
 rtl/led_driver_unix_to_calendar.sv | 96 +++++++++
 rtl/led_driver.sv | 185 ++++++++++++++++++
 tb/tb_led_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// rtl/led_driver_pkg.sv - shared state codes, calendar types and date helpers for the clock display
package led_driver_pkg;

    localparam logic [3:0] TIME_DISP        = 4'd0;
    localparam logic [3:0] DATE_DISP        = 4'd1;
    localparam logic [3:0] TIME_EDIT_SEC    = 4'd2;
    localparam logic [3:0] TIME_EDIT_MIN    = 4'd3;
    localparam logic [3:0] TIME_EDIT_HOUR   = 4'd4;
    localparam logic [3:0] TIME_EDIT_DAY    = 4'd5;
    localparam logic [3:0] TIME_EDIT_MONTH  = 4'd6;
    localparam logic [3:0] TIME_EDIT_YEAR   = 4'd7;
    localparam logic [3:0] ALARM_DISP       = 4'd8;
    localparam logic [3:0] ALARM_EDIT_SEC   = 4'd9;
    localparam logic [3:0] ALARM_EDIT_MIN   = 4'd10;
    localparam logic [3:0] ALARM_EDIT_HOUR  = 4'd11;
    localparam logic [3:0] TIMER_DISP       = 4'd12;
    localparam logic [3:0] TIMER_EDIT_SEC   = 4'd13;
    localparam logic [3:0] TIMER_EDIT_MIN   = 4'd14;
    localparam logic [3:0] TIMER_EDIT_HOUR  = 4'd15;

    localparam logic [3:0]  BLANK        = 4'hF;
    localparam logic [31:0] SECS_PER_DAY = 32'd86400;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    typedef struct packed {
        logic [11:0] year;
        logic [3:0]  month;
        logic [4:0]  day;
        hms_t        tod;
    } cal_t;

    typedef enum logic [1:0] {CV_IDLE, CV_DIV, CV_LATCH} conv_state_t;

    // Every fourth year is leap across the whole 1970-2099 range (2000 included).
    function automatic logic is_leap(input logic [11:0] year);
        return year[1:0] == 2'b00;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [11:0] year, input logic [3:0] month);
        case (month)
            4'd2:                     return is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
            default:                  return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] days_from_civil(input logic [11:0] year, input logic [3:0] month,
                                                    input logic [4:0] day);
        logic [31:0] cum;
        case (month)
            4'd1:    cum = 32'd0;
            4'd2:    cum = 32'd31;
            4'd3:    cum = 32'd59;
            4'd4:    cum = 32'd90;
            4'd5:    cum = 32'd120;
            4'd6:    cum = 32'd151;
            4'd7:    cum = 32'd181;
            4'd8:    cum = 32'd212;
            4'd9:    cum = 32'd243;
            4'd10:   cum = 32'd273;
            4'd11:   cum = 32'd304;
            default: cum = 32'd334;
        endcase
        if (month > 4'd2 && is_leap(year))
            cum = cum + 32'd1;
        return (32'(year) - 32'd1970) * 32'd365 + (32'(year) - 32'd1969) / 32'd4 + cum + 32'(day) - 32'd1;
    endfunction

    function automatic logic [11:0] step_wrap(input logic [11:0] v, input logic [11:0] lo,
                                              input logic [11:0] hi, input logic up);
        if (up)
            return (v >= hi) ? lo : v + 12'd1;
        else
            return (v <= lo) ? hi : v - 12'd1;
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] bcd4(input logic [11:0] v);
        return {4'(v / 12'd1000), 4'((v / 12'd100) % 12'd10), 4'((v / 12'd10) % 12'd10), 4'(v % 12'd10)};
    endfunction

    function automatic logic [31:0] hms_digits(input hms_t v);
        return {BLANK, BLANK, bcd2(7'(v.hour)), bcd2(7'(v.min)), bcd2(7'(v.sec))};
    endfunction

    function automatic hms_t hms_dec(input hms_t v);
        hms_t r;
        r = v;
        if (v.sec != 6'd0) begin
            r.sec = v.sec - 6'd1;
        end else if (v.min != 6'd0) begin
            r.min = v.min - 6'd1;
            r.sec = 6'd59;
        end else if (v.hour != 5'd0) begin
            r.hour = v.hour - 5'd1;
            r.min  = 6'd59;
            r.sec  = 6'd59;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_driver_unix_to_calendar.sv
// rtl/led_driver_unix_to_calendar.sv - serial divide by 86400 then civil-date conversion of Unix seconds
module unix_to_calendar
    import led_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] t,
    output logic        done,
    output cal_t        cal
);

    conv_state_t cv_state, cv_next;
    logic [4:0]  step_cnt;
    logic [31:0] dvd;
    logic [16:0] rem;
    logic [17:0] rem_sh;
    logic        rem_ge;
    logic        step_en, latch_en;
    logic [31:0] z, era, doe, yoe, doy, mp, d, m, y, sod;
    cal_t        civil;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cv_state <= CV_IDLE;
        else
            cv_state <= cv_next;
    end

    // A new start always wins, so a change of t mid-divide simply restarts it.
    always_comb begin
        cv_next = cv_state;
        if (start) begin
            cv_next = CV_DIV;
        end else begin
            case (cv_state)
                CV_DIV:   if (step_cnt == 5'd31) cv_next = CV_LATCH;
                CV_LATCH: cv_next = CV_IDLE;
                default:  cv_next = CV_IDLE;
            endcase
        end
    end

    always_comb begin
        step_en  = (cv_state == CV_DIV) && !start;
        latch_en = (cv_state == CV_LATCH) && !start;
    end

    // dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    assign rem_sh = {rem, dvd[31]};
    assign rem_ge = rem_sh >= 18'd86400;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            dvd      <= '0;
            rem      <= '0;
            done     <= 1'b0;
            cal      <= '0;
        end else begin
            done <= latch_en;
            if (start) begin
                dvd      <= t;
                rem      <= '0;
                step_cnt <= '0;
            end else if (step_en) begin
                rem      <= rem_ge ? 17'(rem_sh - 18'd86400) : 17'(rem_sh);
                dvd      <= {dvd[30:0], rem_ge};
                step_cnt <= step_cnt + 5'd1;
            end
            if (latch_en)
                cal <= civil;
        end
    end

    // Days since 1970-01-01 to year/month/day, March-based era arithmetic.
    always_comb begin
        z   = dvd + 32'd719468;
        era = z / 32'd146097;
        doe = z - era * 32'd146097;
        yoe = (doe - doe / 32'd1460 + doe / 32'd36524 - doe / 32'd146096) / 32'd365;
        doy = doe - (32'd365 * yoe + yoe / 32'd4 - yoe / 32'd100);
        mp  = (32'd5 * doy + 32'd2) / 32'd153;
        d   = doy - (32'd153 * mp + 32'd2) / 32'd5 + 32'd1;
        m   = (mp < 32'd10) ? mp + 32'd3 : mp - 32'd9;
        y   = yoe + era * 32'd400 + ((m <= 32'd2) ? 32'd1 : 32'd0);
        sod = 32'(rem);
        civil.year     = 12'(y);
        civil.month    = 4'(m);
        civil.day      = 5'(d);
        civil.tod.hour = 5'(sod / 32'd3600);
        civil.tod.min  = 6'((sod % 32'd3600) / 32'd60);
        civil.tod.sec  = 6'(sod % 32'd60);
    end

endmodule

// File: rtl/led_driver.sv
// rtl/led_driver.sv - clock page display, field editing, alarm/timer registers and ring request
module led_driver
    import led_driver_pkg::*;
#(
    parameter int TZ_OFFSET = 0,
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  state,
    input  logic [63:0] counter,
    input  logic        up_btn,
    input  logic        down_btn,
    output logic        set_counter,
    output logic        ring,
    output logic [5:0]  led0,
    output logic [5:0]  led1,
    output logic [5:0]  led2,
    output logic [5:0]  led3,
    output logic [5:0]  led4,
    output logic [5:0]  led5,
    output logic [5:0]  led6,
    output logic [5:0]  led7,
    output logic [63:0] counter_out
);

    localparam int         RW       = $clog2(RING_SECS + 1);
    localparam logic [7:0] DOT_MASK = 8'b0001_0100;

    logic [31:0] t, t_prev;
    logic        tick, conv_done;
    cal_t        cal, ed;
    logic [2:0]  up_sr, dn_sr;
    logic        press_up, press_dn, up_ev, dn_ev, press, edit_go;
    logic        in_time_edit, in_alarm_edit, in_timer_edit, timer_run;
    logic        alarm_ev, timer_ev;
    hms_t        alarm, timer, hms_src, hms_ed;
    logic [4:0]  dim;
    logic [31:0] new_secs;
    logic [RW-1:0] ring_cnt;
    logic [31:0] page;
    logic [7:0]  blink_m;
    logic [5:0]  led_q [8];
    logic        unused_hi;

    assign unused_hi = ^counter[63:32];
    assign t    = counter[31:0] + 32'(TZ_OFFSET);
    assign tick = t != t_prev;

    unix_to_calendar u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tick),
        .t     (t),
        .done  (conv_done),
        .cal   (cal)
    );

    // Bit 2 of each shift register is the previous synchronised level for edge detection.
    assign press_up = up_sr[2] & ~up_sr[1];
    assign press_dn = dn_sr[2] & ~dn_sr[1];
    assign up_ev    = press_up & ~press_dn;
    assign dn_ev    = press_dn & ~press_up;
    assign press    = up_ev | dn_ev;
    assign edit_go  = press & ~ring;

    assign in_time_edit  = state inside {[TIME_EDIT_SEC:TIME_EDIT_YEAR]};
    assign in_alarm_edit = state inside {[ALARM_EDIT_SEC:ALARM_EDIT_HOUR]};
    assign in_timer_edit = state inside {[TIMER_EDIT_SEC:TIMER_EDIT_HOUR]};
    assign timer_run     = !in_timer_edit;
    assign alarm_ev      = conv_done && (cal.tod == alarm) && (alarm != '0);
    assign timer_ev      = tick && timer_run && (timer == 17'd1);

    always_comb begin
        ed = cal;
        case (state)
            TIME_EDIT_SEC:   ed.tod.sec  = 6'(step_wrap(12'(cal.tod.sec), 12'd0, 12'd59, up_ev));
            TIME_EDIT_MIN:   ed.tod.min  = 6'(step_wrap(12'(cal.tod.min), 12'd0, 12'd59, up_ev));
            TIME_EDIT_HOUR:  ed.tod.hour = 5'(step_wrap(12'(cal.tod.hour), 12'd0, 12'd23, up_ev));
            TIME_EDIT_DAY:   ed.day      = 5'(step_wrap(12'(cal.day), 12'd1,
                                                        12'(days_in_month(cal.year, cal.month)), up_ev));
            TIME_EDIT_MONTH: ed.month    = 4'(step_wrap(12'(cal.month), 12'd1, 12'd12, up_ev));
            TIME_EDIT_YEAR:  ed.year     = step_wrap(cal.year, 12'd1970, 12'd2099, up_ev);
            default: ;
        endcase
        dim = days_in_month(ed.year, ed.month);
        if (ed.day > dim)
            ed.day = dim;
        new_secs = days_from_civil(ed.year, ed.month, ed.day) * SECS_PER_DAY
                 + 32'(ed.tod.hour) * 32'd3600 + 32'(ed.tod.min) * 32'd60 + 32'(ed.tod.sec)
                 - 32'(TZ_OFFSET);
    end

    always_comb begin
        hms_src = in_alarm_edit ? alarm : timer;
        hms_ed  = hms_src;
        case (state)
            ALARM_EDIT_SEC, TIMER_EDIT_SEC:   hms_ed.sec  = 6'(step_wrap(12'(hms_src.sec), 12'd0, 12'd59, up_ev));
            ALARM_EDIT_MIN, TIMER_EDIT_MIN:   hms_ed.min  = 6'(step_wrap(12'(hms_src.min), 12'd0, 12'd59, up_ev));
            ALARM_EDIT_HOUR, TIMER_EDIT_HOUR: hms_ed.hour = 5'(step_wrap(12'(hms_src.hour), 12'd0, 12'd23, up_ev));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_prev      <= '0;
            up_sr       <= 3'b111;
            dn_sr       <= 3'b111;
            alarm       <= '0;
            timer       <= '0;
            ring        <= 1'b0;
            ring_cnt    <= '0;
            counter_out <= '0;
            set_counter <= 1'b0;
        end else begin
            t_prev      <= t;
            up_sr       <= {up_sr[1:0], up_btn};
            dn_sr       <= {dn_sr[1:0], down_btn};
            set_counter <= 1'b0;
            if (edit_go && in_time_edit) begin
                counter_out <= {32'd0, new_secs};
                set_counter <= 1'b1;
            end
            if (edit_go && in_alarm_edit)
                alarm <= hms_ed;
            if (edit_go && in_timer_edit)
                timer <= hms_ed;
            else if (tick && timer_run && timer != '0)
                timer <= hms_dec(timer);
            // A fresh event outranks a press landing in the same cycle so it is never lost.
            if (alarm_ev || timer_ev) begin
                ring     <= 1'b1;
                ring_cnt <= RW'(RING_SECS);
            end else if (press) begin
                ring <= 1'b0;
            end else if (ring && tick) begin
                if (ring_cnt <= RW'(1))
                    ring <= 1'b0;
                ring_cnt <= ring_cnt - RW'(1);
            end
        end
    end

    always_comb begin
        page    = hms_digits(cal.tod);
        blink_m = 8'h00;
        case (state)
            DATE_DISP, TIME_EDIT_DAY, TIME_EDIT_MONTH, TIME_EDIT_YEAR:
                page = {bcd4(cal.year), bcd2(7'(cal.month)), bcd2(7'(cal.day))};
            ALARM_DISP, ALARM_EDIT_SEC, ALARM_EDIT_MIN, ALARM_EDIT_HOUR:
                page = hms_digits(alarm);
            TIMER_DISP, TIMER_EDIT_SEC, TIMER_EDIT_MIN, TIMER_EDIT_HOUR:
                page = hms_digits(timer);
            default: ;
        endcase
        case (state)
            TIME_EDIT_SEC, TIME_EDIT_DAY, ALARM_EDIT_SEC, TIMER_EDIT_SEC:     blink_m = 8'h03;
            TIME_EDIT_MIN, TIME_EDIT_MONTH, ALARM_EDIT_MIN, TIMER_EDIT_MIN:   blink_m = 8'h0C;
            TIME_EDIT_HOUR, ALARM_EDIT_HOUR, TIMER_EDIT_HOUR:                 blink_m = 8'h30;
            TIME_EDIT_YEAR:                                                   blink_m = 8'hF0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                led_q[i] <= {1'b0, 1'b0, BLANK};
        end else begin
            for (int i = 0; i < 8; i++)
                led_q[i] <= {blink_m[i], DOT_MASK[i], page[4*i +: 4]};
        end
    end

    assign led0 = led_q[0];
    assign led1 = led_q[1];
    assign led2 = led_q[2];
    assign led3 = led_q[3];
    assign led4 = led_q[4];
    assign led5 = led_q[5];
    assign led6 = led_q[6];
    assign led7 = led_q[7];

endmodule

// File: tb/tb_led_driver.sv
// tb/tb_led_driver.sv - scoreboard bench for the clock display and edit engine
module tb_led_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  state = 4'd0;
    logic [63:0] counter = 64'd0;
    logic        up_btn = 1'b1;
    logic        down_btn = 1'b1;
    logic        set_counter, ring;
    logic [5:0]  led0, led1, led2, led3, led4, led5, led6, led7;
    logic [63:0] counter_out;

    led_driver #(.TZ_OFFSET(0), .RING_SECS(60)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .counter     (counter),
        .up_btn      (up_btn),
        .down_btn    (down_btn),
        .set_counter (set_counter),
        .ring        (ring),
        .led0        (led0),
        .led1        (led1),
        .led2        (led2),
        .led3        (led3),
        .led4        (led4),
        .led5        (led5),
        .led6        (led6),
        .led7        (led7),
        .counter_out (counter_out)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [47:0] leds_all;

    assign leds_all = {led7, led6, led5, led4, led3, led2, led1, led0};

    always @(negedge clk)
        if (set_counter === 1'b1)
            got_q.push_back(counter_out);

    function automatic logic [47:0] mk_leds(input logic [31:0] word, input logic [7:0] blink);
        logic [47:0] r;
        logic        dot;
        for (int i = 0; i < 8; i++) begin
            dot = (i == 2) || (i == 4);
            r[6*i +: 6] = {blink[i], dot, word[4*i +: 4]};
        end
        return r;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up);
        if (up) up_btn = 1'b0;
        else    down_btn = 1'b0;
        tick_n(10);
        up_btn   = 1'b1;
        down_btn = 1'b1;
        tick_n(6);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        counter = 64'd1625097600;
        tick_n(3);
        n_cmp++; if (leds_all !== {8{6'h0F}}) begin n_bad++; $display("FAIL reset_leds: got %h want %h", leds_all, {8{6'h0F}}); end
        n_cmp++; if (set_counter !== 1'b0) begin n_bad++; $display("FAIL reset_set_counter: got %b want 0", set_counter); end
        n_cmp++; if (ring !== 1'b0) begin n_bad++; $display("FAIL reset_ring: got %b want 0", ring); end
        n_cmp++; if (counter_out !== 64'd0) begin n_bad++; $display("FAIL reset_counter_out: got %0d want 0", counter_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_time_page;
        state = 4'd0;
        tick_n(50);
        n_cmp++; if (leds_all !== mk_leds(32'hFF000000, 8'h00)) begin n_bad++; $display("FAIL time_page: got %h want %h", leds_all, mk_leds(32'hFF000000, 8'h00)); end
    endtask

    task automatic test_date_page;
        state = 4'd1;
        tick_n(1);
        n_cmp++; if (leds_all !== mk_leds(32'h20210701, 8'h00)) begin n_bad++; $display("FAIL date_page: got %h want %h", leds_all, mk_leds(32'h20210701, 8'h00)); end
    endtask

    task automatic test_field_edits;
        localparam int NE = 7;
        string       e_name [NE] = '{"sec_down", "sec_down_again", "hour_down", "year_up_wrap",
                                     "month_down_clamp", "day_up_wrap_leap", "min_up_wrap"};
        logic [63:0] e_in   [NE] = '{64'd1625097600, 64'd1625097600, 64'd1625097600, 64'd4077261296,
                                     64'd1711843200, 64'd1709164800, 64'd1625101140};
        logic [3:0]  e_st   [NE] = '{4'd2, 4'd2, 4'd4, 4'd7, 4'd6, 4'd5, 4'd3};
        bit          e_up   [NE] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] e_exp  [NE] = '{64'd1625097659, 64'd1625097659, 64'd1625180400, 64'd6352496,
                                     64'd1709164800, 64'd1706745600, 64'd1625097600};
        logic [31:0] e_word [NE] = '{32'hFF000000, 32'hFF000000, 32'hFF000000, 32'h20990315,
                                     32'h20240331, 32'h20240229, 32'hFF005900};
        logic [7:0]  e_blk  [NE] = '{8'h03, 8'h03, 8'h30, 8'hF0, 8'h0C, 8'h03, 8'h0C};
        logic [63:0] g, x;
        for (int k = 0; k < NE; k++) begin
            counter = e_in[k];
            tick_n(50);
            state = e_st[k];
            tick_n(1);
            n_cmp++; if (leds_all !== mk_leds(e_word[k], e_blk[k])) begin n_bad++; $display("FAIL %s_page: got %h want %h", e_name[k], leds_all, mk_leds(e_word[k], e_blk[k])); end
            got_q.delete();
            exp_q.push_back(e_exp[k]);
            press(e_up[k]);
            n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL %s_pulses: got %0d strobe cycles want 1", e_name[k], got_q.size()); end
            x = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL %s_counter_out: got no strobe want %0d", e_name[k], x);
            end else begin
                g = got_q.pop_front();
                if (g !== x) begin n_bad++; $display("FAIL %s_counter_out: got %0d want %0d", e_name[k], g, x); end
            end
            got_q.delete();
        end
    endtask

    task automatic test_edit_display;
        counter = 64'd1625097659;
        state   = 4'd2;
        tick_n(50);
        n_cmp++; if (leds_all !== mk_leds(32'hFF000059, 8'h03)) begin n_bad++; $display("FAIL edit_display: got %h want %h", leds_all, mk_leds(32'hFF000059, 8'h03)); end
    endtask

    task automatic test_both_pressed;
        state = 4'd2;
        got_q.delete();
        up_btn   = 1'b0;
        down_btn = 1'b0;
        tick_n(10);
        up_btn   = 1'b1;
        down_btn = 1'b1;
        tick_n(6);
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL both_pressed: got %0d strobes want 0", got_q.size()); end
    endtask

    task automatic test_alarm;
        got_q.delete();
        state = 4'd9;
        tick_n(1);
        for (int i = 0; i < 5; i++) press(1'b1);
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL alarm_edit_strobe: got %0d strobes want 0", got_q.size()); end
        state = 4'd8;
        tick_n(1);
        n_cmp++; if (leds_all !== mk_leds(32'hFF000005, 8'h00)) begin n_bad++; $display("FAIL alarm_page: got %h want %h", leds_all, mk_leds(32'hFF000005, 8'h00)); end
        counter = 64'd1625097604;
        tick_n(50);
        n_cmp++; if (ring !== 1'b0) begin n_bad++; $display("FAIL alarm_early_ring: got %b want 0", ring); end
        counter = 64'd1625097605;
        tick_n(50);
        n_cmp++; if (ring !== 1'b1) begin n_bad++; $display("FAIL alarm_ring: got %b want 1", ring); end
        state = 4'd9;
        press(1'b1);
        n_cmp++; if (ring !== 1'b0) begin n_bad++; $display("FAIL alarm_press_clear: got %b want 0", ring); end
        n_cmp++; if (leds_all !== mk_leds(32'hFF000005, 8'h03)) begin n_bad++; $display("FAIL alarm_no_edit: got %h want %h", leds_all, mk_leds(32'hFF000005, 8'h03)); end
    endtask

    task automatic test_timer_ring;
        state = 4'd13;
        tick_n(1);
        press(1'b1);
        press(1'b1);
        state = 4'd12;
        tick_n(1);
        n_cmp++; if (leds_all !== mk_leds(32'hFF000002, 8'h00)) begin n_bad++; $display("FAIL timer_page: got %h want %h", leds_all, mk_leds(32'hFF000002, 8'h00)); end
        counter = 64'd1625097606;
        tick_n(50);
        n_cmp++; if (ring !== 1'b0) begin n_bad++; $display("FAIL timer_early_ring: got %b want 0", ring); end
        counter = 64'd1625097607;
        tick_n(5);
        n_cmp++; if (ring !== 1'b1) begin n_bad++; $display("FAIL timer_ring: got %b want 1", ring); end
        for (int k = 1; k < 60; k++) begin
            counter = 64'd1625097607 + 64'(k);
            tick_n(3);
        end
        n_cmp++; if (ring !== 1'b1) begin n_bad++; $display("FAIL ring_hold_59s: got %b want 1", ring); end
        counter = 64'd1625097667;
        tick_n(3);
        n_cmp++; if (ring !== 1'b0) begin n_bad++; $display("FAIL ring_fall_60s: got %b want 0", ring); end
    endtask

    initial begin
        test_reset;
        test_time_page;
        test_date_page;
        test_field_edits;
        test_edit_display;
        test_both_pressed;
        test_alarm;
        test_timer_ring;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
